stage_sequencer: RTL and testbench

Parametrised successor to the fixed four-phase clock generator of the Lua CPU. It drives single-clock stage enables instead of derived clocks, and supports two modes:
- sequential: one stage active at a time;
- pipelined: overlapped stages with valid tracking.

It adds per-stage stall, branch flush with PC redirect, graceful halt and a retire counter. It sits between the CPU top and the fetch/decode/execute/writeback stage blocks.

---
 rtl/lua_cpu_pkg.sv | 39 +++
 rtl/stage_sequencer.sv | 126 ++++++++++++
 tb/tb_stage_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lua_cpu_pkg.sv
// Shared types and helpers for the Lua CPU stage sequencer.
// Holds the sequencer state enum, stage index names and the back-pressure hold chain.
package lua_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } seq_state_t;

  localparam int          PC_WIDTH_DEFAULT = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;
  localparam int STG_WB = 3;

  localparam int MAX_STAGES = 32;

  // A stage is held when it, or any stage downstream of it, holds a live
  // instruction that is stalled; unused upper bits must be passed in as zero.
  function automatic logic [MAX_STAGES-1:0] hold_chain(
    input logic [MAX_STAGES-1:0] stall,
    input logic [MAX_STAGES-1:0] valid
  );
    logic [MAX_STAGES-1:0] hold;
    logic                  acc;
    acc  = 1'b0;
    hold = '0;
    for (int k = MAX_STAGES - 1; k >= 0; k--) begin
      acc     = acc | (stall[k] & valid[k]);
      hold[k] = acc;
    end
    return hold;
  endfunction

endpackage

// File: rtl/stage_sequencer.sv
// Stage-enable sequencer for the Lua CPU: sequential one-hot phases or an overlapped
// pipeline with valid tracking, plus stall, branch flush/redirect, drain-to-halt and retire count.
module stage_sequencer
  import lua_cpu_pkg::*;
#(
  parameter int                  NUM_STAGES  = 4,
  parameter int                  PC_WIDTH    = PC_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEFAULT),
  parameter bit                  PIPELINED   = 1'b0,
  parameter int                  FLUSH_STAGE = STG_EX
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic [NUM_STAGES-1:0] stall,
  input  logic                  flush,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  running,
  output logic                  halted,
  output logic [31:0]           retire_count
);

  localparam int PH_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  seq_state_t            state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [NUM_STAGES-1:0] vld_q, vld_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [31:0]           retire_q;

  logic                  active, flush_eff, live;
  logic [NUM_STAGES-1:0] squash, hold, en, sv;
  logic [MAX_STAGES-1:0] stall_x, vld_x, hold_x;

  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign flush_eff = flush && active;

  always_comb begin
    squash  = '0;
    hold    = '0;
    en      = '0;
    sv      = '0;
    live    = 1'b0;
    vld_d   = vld_q;
    phase_d = phase_q;
    stall_x = '0;
    vld_x   = '0;
    stall_x[NUM_STAGES-1:0] = stall;
    vld_x[NUM_STAGES-1:0]   = vld_q;
    hold_x  = hold_chain(stall_x, vld_x);
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (k < FLUSH_STAGE) squash[k] = flush_eff;
    end
    if (PIPELINED) begin
      hold = hold_x[NUM_STAGES-1:0];
      sv   = vld_q;
      for (int k = 0; k < NUM_STAGES; k++) begin
        en[k] = vld_q[k] && !hold[k] && !squash[k];
      end
      // A stage refills from its upstream neighbour only if it is not held; a
      // held upstream with a free downstream leaves a bubble.
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (squash[k])    vld_d[k] = 1'b0;
        else if (hold[k]) vld_d[k] = vld_q[k];
        else              vld_d[k] = en[k-1];
      end
      if (squash[0])    vld_d[0] = 1'b0;
      else if (hold[0]) vld_d[0] = vld_q[0];
      else              vld_d[0] = (state_q == RUN) && !halt_req;
    end else begin
      // Phase 0 in RUN is the fetch slot; in DRAIN it means nothing is in flight.
      live = (state_q == RUN) || ((state_q == DRAIN) && (phase_q != '0));
      if (live) begin
        sv[phase_q] = 1'b1;
        if (squash[phase_q]) begin
          phase_d = '0;
        end else if (!stall[phase_q]) begin
          en[phase_q] = 1'b1;
          phase_d = (phase_q == PH_W'(NUM_STAGES - 1)) ? '0 : phase_q + PH_W'(1);
        end
      end
    end
    if (flush_eff)  pc_d = redirect_pc;
    else if (en[0]) pc_d = pc_q + PC_WIDTH'(1);
    else            pc_d = pc_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = RUN;
      RUN:     if (halt_req)  state_d = DRAIN;
      DRAIN:   if (sv == '0)  state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      vld_q    <= '0;
      phase_q  <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      vld_q    <= vld_d;
      phase_q  <= phase_d;
      retire_q <= retire_q + 32'(en[NUM_STAGES-1]);
    end
  end

  assign stage_en     = en;
  assign stage_valid  = sv;
  assign pc           = pc_q;
  assign running      = active;
  assign halted       = (state_q == HALTED);
  assign retire_count = retire_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: a sequential and a pipelined instance share stimulus and are
// compared every cycle against an instruction-occupancy model of the sequencing rules.
module tb_stage_sequencer;

  localparam int N  = 4;
  localparam int FS = 2;

  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_HALTED} mst_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  stall = '0;
  logic [31:0] redirect_pc = '0;

  logic [3:0]  s_en, s_valid, p_en, p_valid;
  logic [31:0] s_pc, s_retire, p_retire;
  logic [7:0]  p_pc;
  logic        s_running, s_halted, p_running, p_halted;

  always #5 clk = ~clk;

  stage_sequencer #(.NUM_STAGES(4), .PC_WIDTH(32), .RESET_PC(32'h0), .PIPELINED(1'b0),
                    .FLUSH_STAGE(2)) u_seq (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .stall(stall),
    .flush(flush), .redirect_pc(redirect_pc), .stage_en(s_en), .stage_valid(s_valid),
    .pc(s_pc), .running(s_running), .halted(s_halted), .retire_count(s_retire));

  stage_sequencer #(.NUM_STAGES(4), .PC_WIDTH(8), .RESET_PC(8'hF0), .PIPELINED(1'b1),
                    .FLUSH_STAGE(2)) u_pipe (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .stall(stall),
    .flush(flush), .redirect_pc(redirect_pc[7:0]), .stage_en(p_en), .stage_valid(p_valid),
    .pc(p_pc), .running(p_running), .halted(p_halted), .retire_count(p_retire));

  int n_assert = 0;
  int n_fail   = 0;

  // Sequential model: one instruction position, live or not.
  mst_t        s_st;
  int          s_pos;
  logic [31:0] s_pcm, s_ret;
  logic        s_live, s_fl, s_sq;
  logic [3:0]  e_s_en, e_s_valid;

  // Pipelined model: per-stage occupancy.
  mst_t        p_st;
  logic [3:0]  p_occ, held, fire;
  logic [7:0]  p_pcm;
  logic [31:0] p_ret;
  logic        p_fl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    s_st = M_IDLE; s_pos = 0; s_pcm = 32'h0;  s_ret = 0;
    p_st = M_IDLE; p_occ = '0; p_pcm = 8'hF0; p_ret = 0;
  endtask

  task automatic model_outputs();
    s_live = (s_st == M_RUN) || (s_st == M_DRAIN && s_pos != 0);
    s_fl   = flush && (s_st == M_RUN || s_st == M_DRAIN);
    s_sq   = s_fl && (s_pos < FS);
    e_s_valid = s_live ? (4'b0001 << s_pos) : 4'b0000;
    e_s_en    = (s_live && !s_sq && !stall[s_pos]) ? (4'b0001 << s_pos) : 4'b0000;
    p_fl = flush && (p_st == M_RUN || p_st == M_DRAIN);
    for (int k = 0; k < N; k++) begin
      held[k] = 1'b0;
      for (int j = k; j < N; j++) if (stall[j] && p_occ[j]) held[k] = 1'b1;
      fire[k] = p_occ[k] && !held[k] && !(p_fl && k < FS);
    end
  endtask

  task automatic check_all();
    chk("s_en", 64'(s_en), 64'(e_s_en));
    chk("s_valid", 64'(s_valid), 64'(e_s_valid));
    chk("s_pc", 64'(s_pc), 64'(s_pcm));
    chk("s_running", 64'(s_running), 64'(s_st == M_RUN || s_st == M_DRAIN));
    chk("s_halted", 64'(s_halted), 64'(s_st == M_HALTED));
    chk("s_retire", 64'(s_retire), 64'(s_ret));
    chk("p_en", 64'(p_en), 64'(fire));
    chk("p_valid", 64'(p_valid), 64'(p_occ));
    chk("p_pc", 64'(p_pc), 64'(p_pcm));
    chk("p_running", 64'(p_running), 64'(p_st == M_RUN || p_st == M_DRAIN));
    chk("p_halted", 64'(p_halted), 64'(p_st == M_HALTED));
    chk("p_retire", 64'(p_retire), 64'(p_ret));
  endtask

  task automatic model_advance();
    logic [3:0] nocc;
    if (s_fl) s_pcm = redirect_pc; else if (e_s_en[0]) s_pcm = s_pcm + 1;
    if (e_s_en[3]) s_ret = s_ret + 1;
    if (s_live && s_sq) s_pos = 0; else if (e_s_en != 0) s_pos = (s_pos + 1) % N;
    case (s_st)
      M_IDLE:  if (start) s_st = M_RUN;
      M_RUN:   if (halt_req) s_st = M_DRAIN;
      M_DRAIN: if (e_s_valid == 0) s_st = M_HALTED;
      default: ;
    endcase
    if (p_fl) p_pcm = redirect_pc[7:0]; else if (fire[0]) p_pcm = p_pcm + 8'd1;
    if (fire[3]) p_ret = p_ret + 1;
    for (int k = N - 1; k >= 1; k--) begin
      if (p_fl && k < FS) nocc[k] = 1'b0;
      else if (held[k])   nocc[k] = p_occ[k];
      else                nocc[k] = fire[k-1];
    end
    if (p_fl)         nocc[0] = 1'b0;
    else if (held[0]) nocc[0] = p_occ[0];
    else              nocc[0] = (p_st == M_RUN) && !halt_req;
    case (p_st)
      M_IDLE:  if (start) p_st = M_RUN;
      M_RUN:   if (halt_req) p_st = M_DRAIN;
      M_DRAIN: if (p_occ == 0) p_st = M_HALTED;
      default: ;
    endcase
    p_occ = nocc;
  endtask

  task automatic step(input logic [3:0] st, input logic fl, input logic [31:0] rd,
                      input logic sta, input logic hr);
    @(negedge clk);
    stall = st; flush = fl; redirect_pc = rd; start = sta; halt_req = hr;
    #1;
    model_outputs();
    check_all();
    model_advance();
  endtask

  task automatic rand_step(input int halt_odds);
    step(4'($urandom) & 4'($urandom), $urandom_range(0, 9) == 0, $urandom,
         $urandom_range(0, 3) == 0, (halt_odds > 0) && ($urandom_range(1, halt_odds) == 1));
  endtask

  // Reset lands 2 time units after a rising edge, i.e. between edges.
  task automatic async_reset();
    step(4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    model_outputs();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0]  pc_before;
    logic [31:0] r0;
    model_reset();
    #12;
    model_outputs();
    check_all();
    @(negedge clk);
    reset = 1'b0;

    step(4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(4'h0, 1'b1, 32'h99, 1'b0, 1'b0);
    step(4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("seq_en_rotate", 64'(s_en), 64'(4'b0001 << (i % 4)));
      if (i == 1) chk("seq_pc_first_if", 64'(s_pc), 64'd1);
    end
    @(posedge clk); #1;
    chk("seq_retire_8", 64'(s_retire), 64'd2);
    chk("pipe_full", 64'(p_valid), 64'hF);

    pc_before = p_pcm;
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pipe_stall_valid", 64'(p_valid), 64'b0111);
    chk("pipe_stall_pc", 64'(p_pc), 64'(pc_before));

    step(4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(4'h0, 1'b1, 32'h40, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pipe_flush_valid", 64'(p_valid), 64'b1000);
    chk("pipe_flush_pc", 64'(p_pc), 64'h40);

    for (int tgt = 1; tgt <= 2; tgt++) begin
      for (int i = 0; i < 8 && s_pos != tgt; i++) step(4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("seq_pos_wait", 64'(s_pos), 64'(tgt));
      r0 = s_ret;
      step(4'h0, 1'b1, 32'h80 + 32'(tgt), 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("seq_flush_pc", 64'(s_pc), 64'h80 + 64'(tgt));
      chk("seq_flush_valid", 64'(s_valid), (tgt == 1) ? 64'b0001 : 64'b1000);
      chk("seq_flush_retire", 64'(s_retire), 64'(r0));
      if (tgt == 2) begin
        step(4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("seq_flush_late_retires", 64'(s_retire), 64'(r0) + 64'd1);
      end
    end

    for (int i = 0; i < 300; i++) rand_step(0);

    for (int i = 0; i < 5; i++) step(4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    r0 = p_ret;
    step(4'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 12 && !(p_st == M_HALTED && s_st == M_HALTED); i++)
      step(4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("halt_pipe_halted", 64'(p_halted), 64'd1);
    chk("halt_seq_halted", 64'(s_halted), 64'd1);
    chk("halt_pipe_retire", 64'(p_retire), 64'(r0) + 64'd4);
    for (int i = 0; i < 3; i++) step(4'h0, 1'b0, 32'h0, 1'b1, 1'b0);

    async_reset();
    step(4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) rand_step(0);
    async_reset();

    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 50) async_reset();
      rand_step(40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
